// File: rtl/rvga_types.sv
// rtl/rvga_types.sv - shared types for the rvga integer pipeline
// Purpose: word, register-index and ALU-op types used across pipeline stages.
// Ports: none (package).
package rvga_types;

    localparam int rvga_word_width_lp = 32;
    localparam int rvga_reg_width_lp  = 5;

    typedef logic [rvga_word_width_lp-1:0] rvga_word;
    typedef logic [rvga_reg_width_lp-1:0]  rvga_reg;

    // ALU operation select; ART_ADD must stay at encoding 0 because the
    // register-fetch stage resets its op output to all-zero.
    typedef enum logic [3:0] {
        ART_ADD  = 4'd0,
        ART_SLL  = 4'd1,
        ART_SLT  = 4'd2,
        ART_SLTU = 4'd3,
        ART_XOR  = 4'd4,
        ART_SRL  = 4'd5,
        ART_OR   = 4'd6,
        ART_AND  = 4'd7,
        ART_SUB  = 4'd8,
        ART_SRA  = 4'd9
    } rvga_artop;

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - integer register file, one write port, two async read ports
// Purpose: holds the architectural registers; index 0 is hardwired to zero.
// Ports:
//   clk, rst          clock, synchronous active-low reset (clears all entries)
//   i_w_v/addr/data   write port, commits on the rising edge
//   i_r0_addr/o_r0_data, i_r1_addr/o_r1_data
//                     combinational read ports returning the pre-edge contents
module regfile #(
    parameter  int width_p   = 32,
    parameter  int reg_els_p = 32,
    localparam int idx_w_lp  = $clog2(reg_els_p)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_w_v,
    input  logic [idx_w_lp-1:0] i_w_addr,
    input  logic [width_p-1:0]  i_w_data,
    input  logic [idx_w_lp-1:0] i_r0_addr,
    output logic [width_p-1:0]  o_r0_data,
    input  logic [idx_w_lp-1:0] i_r1_addr,
    output logic [width_p-1:0]  o_r1_data
);

    logic [width_p-1:0] r_mem [reg_els_p];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < reg_els_p; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_w_v && (i_w_addr != '0)) begin
            r_mem[i_w_addr] <= i_w_data;
        end
    end

    // Reads see the old value on a same-cycle write; any write-first
    // forwarding is the reader's responsibility.
    assign o_r0_data = (i_r0_addr == '0) ? '0 : r_mem[i_r0_addr];
    assign o_r1_data = (i_r1_addr == '0) ? '0 : r_mem[i_r1_addr];

endmodule

// File: rtl/rfetch_pipe.sv
// rtl/rfetch_pipe.sv - register-fetch pipeline stage between decode and execute
// Purpose: reads source operands from the regfile on accept and holds a single
//   registered instruction for execute, with optional writeback bypass.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   decode_rfetch_*               instruction offer from decode (valid/ready)
//   rfetch_execute_*              registered instruction to execute (valid/ready)
//   writeback_rfetch_rd_*         regfile write port from writeback
//   flush                         discard the held instruction
module rfetch_pipe
    import rvga_types::*;
#(
    parameter  int width_p     = 32,
    parameter  int reg_els_p   = 32,
    parameter  int bypass_en_p = 1,
    localparam int idx_w_lp    = $clog2(reg_els_p)
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                decode_rfetch_v,
    output logic                rfetch_decode_ready,
    input  logic [idx_w_lp-1:0] decode_rfetch_rs1,
    input  logic [idx_w_lp-1:0] decode_rfetch_rs2,
    input  logic [idx_w_lp-1:0] decode_rfetch_rd,
    input  logic [width_p-1:0]  decode_rfetch_imm_data,
    input  logic                decode_rfetch_imm_v,
    input  rvga_artop           decode_rfetch_artop,
    input  logic                decode_rfetch_alt_art,

    output logic                rfetch_execute_v,
    input  logic                execute_rfetch_ready,
    output logic [idx_w_lp-1:0] rfetch_execute_rs1,
    output logic [idx_w_lp-1:0] rfetch_execute_rs2,
    output logic [idx_w_lp-1:0] rfetch_execute_rd,
    output logic [width_p-1:0]  rfetch_execute_imm_data,
    output logic                rfetch_execute_imm_v,
    output rvga_artop           rfetch_execute_artop,
    output logic                rfetch_execute_alt_art,
    output logic [width_p-1:0]  rfetch_execute_rs1_data,
    output logic [width_p-1:0]  rfetch_execute_rs2_data,

    input  logic                writeback_rfetch_rd_w_v,
    input  logic [idx_w_lp-1:0] writeback_rfetch_rd,
    input  logic [width_p-1:0]  writeback_rfetch_rd_data,

    input  logic                flush
);

    logic                r_v;
    logic [idx_w_lp-1:0] r_rs1;
    logic [idx_w_lp-1:0] r_rs2;
    logic [idx_w_lp-1:0] r_rd;
    logic [width_p-1:0]  r_imm_data;
    logic                r_imm_v;
    rvga_artop           r_artop;
    logic                r_alt_art;
    logic [width_p-1:0]  r_rs1_data;
    logic [width_p-1:0]  r_rs2_data;

    logic                w_ready;
    logic                w_accept;
    logic                w_issue;
    logic                w_stall;
    logic                w_wb_fwd_v;
    logic                w_acc_fwd_rs1;
    logic                w_acc_fwd_rs2;
    logic                w_held_fwd_rs1;
    logic                w_held_fwd_rs2;
    logic [width_p-1:0]  w_rf_rs1_data;
    logic [width_p-1:0]  w_rf_rs2_data;
    logic [width_p-1:0]  w_rs1_data;
    logic [width_p-1:0]  w_rs2_data;

    regfile #(
        .width_p   (width_p),
        .reg_els_p (reg_els_p)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_w_v     (writeback_rfetch_rd_w_v),
        .i_w_addr  (writeback_rfetch_rd),
        .i_w_data  (writeback_rfetch_rd_data),
        .i_r0_addr (decode_rfetch_rs1),
        .o_r0_data (w_rf_rs1_data),
        .i_r1_addr (decode_rfetch_rs2),
        .o_r1_data (w_rf_rs2_data)
    );

    assign w_ready  = !r_v || execute_rfetch_ready;
    assign w_accept = decode_rfetch_v && w_ready;
    assign w_issue  = r_v && execute_rfetch_ready;
    assign w_stall  = r_v && !execute_rfetch_ready;

    // A writeback to x0 never forwards: the regfile ignores it, so the
    // forwarded value must be the architectural zero as well.
    assign w_wb_fwd_v     = (bypass_en_p != 0) && writeback_rfetch_rd_w_v
                            && (writeback_rfetch_rd != '0);
    assign w_acc_fwd_rs1  = w_wb_fwd_v && (writeback_rfetch_rd == decode_rfetch_rs1);
    assign w_acc_fwd_rs2  = w_wb_fwd_v && (writeback_rfetch_rd == decode_rfetch_rs2);
    assign w_held_fwd_rs1 = w_wb_fwd_v && (writeback_rfetch_rd == r_rs1);
    assign w_held_fwd_rs2 = w_wb_fwd_v && (writeback_rfetch_rd == r_rs2);

    assign w_rs1_data = w_acc_fwd_rs1 ? writeback_rfetch_rd_data : w_rf_rs1_data;
    assign w_rs2_data = w_acc_fwd_rs2 ? writeback_rfetch_rd_data : w_rf_rs2_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v        <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_imm_data <= '0;
            r_imm_v    <= 1'b0;
            r_artop    <= ART_ADD;
            r_alt_art  <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
        end else begin
            if (flush) begin
                r_v <= 1'b0;
            end else if (w_accept) begin
                r_v <= 1'b1;
            end else if (w_issue) begin
                r_v <= 1'b0;
            end

            if (w_accept) begin
                r_rs1      <= decode_rfetch_rs1;
                r_rs2      <= decode_rfetch_rs2;
                r_rd       <= decode_rfetch_rd;
                r_imm_data <= decode_rfetch_imm_data;
                r_imm_v    <= decode_rfetch_imm_v;
                r_artop    <= decode_rfetch_artop;
                r_alt_art  <= decode_rfetch_alt_art;
                r_rs1_data <= w_rs1_data;
                r_rs2_data <= w_rs2_data;
            end else if (w_stall) begin
                // Keep a stalled instruction's operands current so execute
                // never consumes a value that writeback has since replaced.
                if (w_held_fwd_rs1) begin
                    r_rs1_data <= writeback_rfetch_rd_data;
                end
                if (w_held_fwd_rs2) begin
                    r_rs2_data <= writeback_rfetch_rd_data;
                end
            end
        end
    end

    assign rfetch_decode_ready     = w_ready;
    assign rfetch_execute_v        = r_v;
    assign rfetch_execute_rs1      = r_rs1;
    assign rfetch_execute_rs2      = r_rs2;
    assign rfetch_execute_rd       = r_rd;
    assign rfetch_execute_imm_data = r_imm_data;
    assign rfetch_execute_imm_v    = r_imm_v;
    assign rfetch_execute_artop    = r_artop;
    assign rfetch_execute_alt_art  = r_alt_art;
    assign rfetch_execute_rs1_data = r_rs1_data;
    assign rfetch_execute_rs2_data = r_rs2_data;

endmodule

// File: tb/tb_rfetch_pipe.sv
// tb/tb_rfetch_pipe.sv - scoreboard bench for rfetch_pipe (bypass on and off)
module tb_rfetch_pipe;
    import rvga_types::*;

    typedef struct {
        rvga_reg   rs1;
        rvga_reg   rs2;
        rvga_reg   rd;
        rvga_word  imm;
        logic      imm_v;
        rvga_artop artop;
        logic      alt;
        rvga_word  d1;
        rvga_word  d2;
        rvga_word  n1;
        rvga_word  n2;
    } exp_t;

    logic      clk = 1'b0;
    logic      rst;
    logic      decode_rfetch_v;
    rvga_reg   decode_rfetch_rs1, decode_rfetch_rs2, decode_rfetch_rd;
    rvga_word  decode_rfetch_imm_data;
    logic      decode_rfetch_imm_v;
    rvga_artop decode_rfetch_artop;
    logic      decode_rfetch_alt_art;
    logic      execute_rfetch_ready;
    logic      writeback_rfetch_rd_w_v;
    rvga_reg   writeback_rfetch_rd;
    rvga_word  writeback_rfetch_rd_data;
    logic      flush;

    logic      ready_a, v_a, imm_v_a, alt_a;
    rvga_reg   rs1_a, rs2_a, rd_a;
    rvga_word  imm_a, d1_a, d2_a;
    rvga_artop artop_a;

    logic      ready_b, v_b, imm_v_b, alt_b;
    rvga_reg   rs1_b, rs2_b, rd_b;
    rvga_word  imm_b, d1_b, d2_b;
    rvga_artop artop_b;

    exp_t      exp_q[$];
    int        issue_cyc[$];
    int        cyc = 0;
    int        n_cmp = 0;
    int        n_bad = 0;

    rvga_reg   b2b_reg[4] = '{5'd3, 5'd5, 5'd7, 5'd9};
    rvga_word  b2b_val[4] = '{32'h11, 32'h22, 32'hDEADBEEF, 32'h99};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rfetch_pipe #(.width_p(32), .reg_els_p(32), .bypass_en_p(1)) u_dut (
        .clk(clk), .rst(rst),
        .decode_rfetch_v(decode_rfetch_v), .rfetch_decode_ready(ready_a),
        .decode_rfetch_rs1(decode_rfetch_rs1), .decode_rfetch_rs2(decode_rfetch_rs2),
        .decode_rfetch_rd(decode_rfetch_rd), .decode_rfetch_imm_data(decode_rfetch_imm_data),
        .decode_rfetch_imm_v(decode_rfetch_imm_v), .decode_rfetch_artop(decode_rfetch_artop),
        .decode_rfetch_alt_art(decode_rfetch_alt_art),
        .rfetch_execute_v(v_a), .execute_rfetch_ready(execute_rfetch_ready),
        .rfetch_execute_rs1(rs1_a), .rfetch_execute_rs2(rs2_a), .rfetch_execute_rd(rd_a),
        .rfetch_execute_imm_data(imm_a), .rfetch_execute_imm_v(imm_v_a),
        .rfetch_execute_artop(artop_a), .rfetch_execute_alt_art(alt_a),
        .rfetch_execute_rs1_data(d1_a), .rfetch_execute_rs2_data(d2_a),
        .writeback_rfetch_rd_w_v(writeback_rfetch_rd_w_v),
        .writeback_rfetch_rd(writeback_rfetch_rd),
        .writeback_rfetch_rd_data(writeback_rfetch_rd_data),
        .flush(flush)
    );

    rfetch_pipe #(.width_p(32), .reg_els_p(32), .bypass_en_p(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .decode_rfetch_v(decode_rfetch_v), .rfetch_decode_ready(ready_b),
        .decode_rfetch_rs1(decode_rfetch_rs1), .decode_rfetch_rs2(decode_rfetch_rs2),
        .decode_rfetch_rd(decode_rfetch_rd), .decode_rfetch_imm_data(decode_rfetch_imm_data),
        .decode_rfetch_imm_v(decode_rfetch_imm_v), .decode_rfetch_artop(decode_rfetch_artop),
        .decode_rfetch_alt_art(decode_rfetch_alt_art),
        .rfetch_execute_v(v_b), .execute_rfetch_ready(execute_rfetch_ready),
        .rfetch_execute_rs1(rs1_b), .rfetch_execute_rs2(rs2_b), .rfetch_execute_rd(rd_b),
        .rfetch_execute_imm_data(imm_b), .rfetch_execute_imm_v(imm_v_b),
        .rfetch_execute_artop(artop_b), .rfetch_execute_alt_art(alt_b),
        .rfetch_execute_rs1_data(d1_b), .rfetch_execute_rs2_data(d2_b),
        .writeback_rfetch_rd_w_v(writeback_rfetch_rd_w_v),
        .writeback_rfetch_rd(writeback_rfetch_rd),
        .writeback_rfetch_rd_data(writeback_rfetch_rd_data),
        .flush(flush)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input rvga_reg a, input rvga_reg b, input rvga_reg d,
                         input rvga_word imm, input logic iv, input rvga_artop op,
                         input logic alt);
        decode_rfetch_v        = 1'b1;
        decode_rfetch_rs1      = a;
        decode_rfetch_rs2      = b;
        decode_rfetch_rd       = d;
        decode_rfetch_imm_data = imm;
        decode_rfetch_imm_v    = iv;
        decode_rfetch_artop    = op;
        decode_rfetch_alt_art  = alt;
    endtask

    task automatic expect_issue(input rvga_word d1, input rvga_word d2,
                                input rvga_word n1, input rvga_word n2);
        exp_t e;
        e.rs1 = decode_rfetch_rs1;  e.rs2 = decode_rfetch_rs2;  e.rd = decode_rfetch_rd;
        e.imm = decode_rfetch_imm_data;  e.imm_v = decode_rfetch_imm_v;
        e.artop = decode_rfetch_artop;   e.alt = decode_rfetch_alt_art;
        e.d1 = d1;  e.d2 = d2;  e.n1 = n1;  e.n2 = n2;
        exp_q.push_back(e);
    endtask

    task automatic wb_write(input rvga_reg r, input rvga_word d);
        writeback_rfetch_rd_w_v  = 1'b1;
        writeback_rfetch_rd      = r;
        writeback_rfetch_rd_data = d;
        tick();
        writeback_rfetch_rd_w_v  = 1'b0;
    endtask

    // Monitor: every issue pops one expected instruction and compares both DUTs.
    always @(negedge clk) begin
        if (rst === 1'b1 && v_a === 1'b1 && execute_rfetch_ready === 1'b1) begin
            exp_t e;
            issue_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL issue_unexpected: got issue at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rs1",      32'(rs1_a),   32'(e.rs1));
                chk("rs2",      32'(rs2_a),   32'(e.rs2));
                chk("rd",       32'(rd_a),    32'(e.rd));
                chk("imm",      imm_a,        e.imm);
                chk("imm_v",    32'(imm_v_a), 32'(e.imm_v));
                chk("artop",    32'(artop_a), 32'(e.artop));
                chk("alt_art",  32'(alt_a),   32'(e.alt));
                chk("rs1_data", d1_a,         e.d1);
                chk("rs2_data", d2_a,         e.d2);
                chk("nb_v",     32'(v_b),     32'd1);
                chk("nb_rs1_data", d1_b,      e.n1);
                chk("nb_rs2_data", d2_b,      e.n2);
            end
        end
    end

    initial begin
        int b2b_base;
        int waited;
        rst = 1'b0;
        decode_rfetch_v = 1'b0;
        decode_rfetch_rs1 = '0;  decode_rfetch_rs2 = '0;  decode_rfetch_rd = '0;
        decode_rfetch_imm_data = '0;  decode_rfetch_imm_v = 1'b0;
        decode_rfetch_artop = ART_ADD;  decode_rfetch_alt_art = 1'b0;
        execute_rfetch_ready = 1'b1;
        writeback_rfetch_rd_w_v = 1'b0;  writeback_rfetch_rd = '0;
        writeback_rfetch_rd_data = '0;
        flush = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_v",        32'(v_a),     32'd0);
        chk("rst_ready",    32'(ready_a), 32'd1);
        chk("rst_rs1_data", d1_a,         32'd0);
        chk("rst_rs2_data", d2_a,         32'd0);
        chk("rst_rd",       32'(rd_a),    32'd0);
        chk("rst_imm",      imm_a,        32'd0);
        chk("rst_nb_v",     32'(v_b),     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Preload registers (x0 write must be ignored)
        wb_write(5'd3, 32'h11);
        wb_write(5'd5, 32'h22);
        wb_write(5'd7, 32'h1234);
        wb_write(5'd9, 32'h99);
        wb_write(5'd0, 32'hFFFF);

        // Basic accept, 1-cycle latency
        offer(5'd3, 5'd5, 5'd1, 32'hA, 1'b1, ART_ADD, 1'b0);
        expect_issue(32'h11, 32'h22, 32'h11, 32'h22);
        tick();
        decode_rfetch_v = 1'b0;
        tick();

        // Same-cycle writeback: forwarded with bypass, old value without
        offer(5'd7, 5'd0, 5'd2, 32'h0, 1'b0, ART_SUB, 1'b1);
        writeback_rfetch_rd_w_v = 1'b1;
        writeback_rfetch_rd = 5'd7;
        writeback_rfetch_rd_data = 32'hDEADBEEF;
        expect_issue(32'hDEADBEEF, 32'h0, 32'h1234, 32'h0);
        tick();
        decode_rfetch_v = 1'b0;
        writeback_rfetch_rd_w_v = 1'b0;
        tick();

        // x0 reads zero even with a same-cycle write to x0
        offer(5'd0, 5'd0, 5'd3, 32'hFFFF, 1'b1, ART_OR, 1'b0);
        writeback_rfetch_rd_w_v = 1'b1;
        writeback_rfetch_rd = 5'd0;
        writeback_rfetch_rd_data = 32'hFFFF;
        expect_issue(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        decode_rfetch_v = 1'b0;
        writeback_rfetch_rd_w_v = 1'b0;
        tick();

        // Back-to-back accepts, no bubbles
        b2b_base = issue_cyc.size();
        for (int i = 0; i < 4; i++) begin
            offer(b2b_reg[i], b2b_reg[(i + 1) % 4], rvga_reg'(i + 10), 32'(i), 1'b1,
                  ART_XOR, i[0]);
            expect_issue(b2b_val[i], b2b_val[(i + 1) % 4], b2b_val[i], b2b_val[(i + 1) % 4]);
            tick();
        end
        decode_rfetch_v = 1'b0;
        tick();
        tick();
        chk("b2b_issue_count", 32'(issue_cyc.size() - b2b_base), 32'd4);
        if (issue_cyc.size() - b2b_base == 4) begin
            chk("b2b_consecutive", 32'(issue_cyc[b2b_base + 3] - issue_cyc[b2b_base]), 32'd3);
        end

        // Stall with held rs2=9, then refresh from writeback
        execute_rfetch_ready = 1'b0;
        offer(5'd3, 5'd9, 5'd4, 32'h77, 1'b1, ART_AND, 1'b0);
        expect_issue(32'h11, 32'h55, 32'h11, 32'h99);
        tick();
        decode_rfetch_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", 32'(ready_a), 32'd0);
            chk("stall_v",     32'(v_a),     32'd1);
            tick();
        end
        wb_write(5'd9, 32'h55);
        @(negedge clk);
        chk("refresh_rs2_data",    d2_a,      32'h55);
        chk("refresh_rs1_data",    d1_a,      32'h11);
        chk("refresh_rd",          32'(rd_a), 32'd4);
        chk("refresh_imm",         imm_a,     32'h77);
        chk("refresh_nb_rs2_data", d2_b,      32'h99);
        chk("refresh_ready",       32'(ready_a), 32'd0);
        @(posedge clk);
        #1;
        execute_rfetch_ready = 1'b1;
        tick();

        // Flush while stalled
        execute_rfetch_ready = 1'b0;
        offer(5'd5, 5'd3, 5'd6, 32'h1, 1'b0, ART_SLL, 1'b0);
        tick();
        decode_rfetch_v = 1'b0;
        @(negedge clk);
        chk("preflush_v", 32'(v_a), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_v",    32'(v_a), 32'd0);
        chk("flush_nb_v", 32'(v_b), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-stall, with a dropped offer; regfile cleared afterwards
        offer(5'd3, 5'd5, 5'd7, 32'h2, 1'b1, ART_SRL, 1'b1);
        tick();
        decode_rfetch_v = 1'b0;
        @(negedge clk);
        chk("prerst_v", 32'(v_a), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        offer(5'd9, 5'd9, 5'd8, 32'h3, 1'b1, ART_SUB, 1'b1);
        tick();
        @(negedge clk);
        chk("midrst_v",        32'(v_a),     32'd0);
        chk("midrst_ready",    32'(ready_a), 32'd1);
        chk("midrst_rs1_data", d1_a,         32'd0);
        chk("midrst_rs2_data", d2_a,         32'd0);
        chk("midrst_rd",       32'(rd_a),    32'd0);
        chk("midrst_imm",      imm_a,        32'd0);
        chk("midrst_imm_v",    32'(imm_v_a), 32'd0);
        chk("midrst_artop",    32'(artop_a), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        execute_rfetch_ready = 1'b1;
        offer(5'd3, 5'd9, 5'd5, 32'h4, 1'b0, ART_ADD, 1'b0);
        expect_issue(32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        decode_rfetch_v = 1'b0;
        tick();

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            tick();
            waited++;
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
